// File: rtl/pci_target_responder.sv
// Purpose: PCI-style target; claims hit transactions, inserts wait states, completes or disconnects data phases.
// Latency: devsel one cycle after the address phase; first trdy WAIT_STATES+1 cycles after claim.
// Backpressure: initiator stalls via irdy; target stalls via wait states and disconnects with stop at BURST_LIMIT.
module pci_target_responder #(
    parameter int WAIT_STATES = 1,
    parameter int BURST_LIMIT = 4,
    parameter int CNT_W       = 4
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             frame,
    input  logic             irdy,
    input  logic             addr_hit,
    output logic             trdy,
    output logic             stop,
    output logic             devsel,
    output logic             data_phase,
    output logic [CNT_W-1:0] xfer_count,
    output logic             xfer
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IGNORE,
        S_DECODE,
        S_WAIT,
        S_DATA,
        S_DISC,
        S_TURN
    } state_t;

    // Wait counter starts one below WAIT_STATES because the load cycle itself is DECODE.
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t           state;
    state_t           state_nxt;
    logic             frame_q;
    logic [3:0]       wait_cnt;
    logic             addr_phase;
    logic             bus_idle;
    logic             xfer_now;
    logic [CNT_W-1:0] cnt_inc;
    logic             burst_done;

    assign addr_phase = !frame && frame_q;
    assign bus_idle   = frame && irdy;
    assign xfer_now   = !irdy && !trdy;
    assign cnt_inc    = (xfer_count == '1) ? xfer_count : xfer_count + 1'b1;
    assign burst_done = (cnt_inc == CNT_W'(BURST_LIMIT));

    // State, frame history, wait counter and transfer bookkeeping.
    always_ff @(posedge mclk) begin
        if (rst) begin
            state      <= S_IDLE;
            frame_q    <= 1'b1;
            wait_cnt   <= '0;
            xfer_count <= '0;
            xfer       <= 1'b0;
        end else begin
            state   <= state_nxt;
            frame_q <= frame;
            xfer    <= xfer_now;
            if (state == S_DECODE) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == S_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (state_nxt == S_DECODE) begin
                xfer_count <= '0;
            end else if (xfer_now) begin
                xfer_count <= cnt_inc;
            end
        end
    end

    // Next-state decode; a bus-idle abort takes priority only when no transfer is possible.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (addr_phase) begin
                    state_nxt = addr_hit ? S_DECODE : S_IGNORE;
                end
            end
            S_IGNORE: begin
                if (bus_idle) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DECODE: begin
                if (bus_idle) begin
                    state_nxt = S_TURN;
                end else if (WAIT_STATES == 0) begin
                    state_nxt = S_DATA;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_idle) begin
                    state_nxt = S_TURN;
                end else if (wait_cnt == '0) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer_now) begin
                    if (frame) begin
                        state_nxt = S_TURN;
                    end else if (burst_done) begin
                        state_nxt = S_DISC;
                    end
                end else if (bus_idle) begin
                    state_nxt = S_TURN;
                end
            end
            S_DISC: begin
                if (frame) begin
                    state_nxt = S_TURN;
                end
            end
            S_TURN: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs are a pure decode of the state register.
    always_comb begin
        trdy       = 1'b1;
        stop       = 1'b1;
        devsel     = 1'b1;
        data_phase = 1'b0;
        case (state)
            S_DECODE, S_WAIT: begin
                devsel     = 1'b0;
                data_phase = 1'b1;
            end
            S_DATA: begin
                trdy       = 1'b0;
                devsel     = 1'b0;
                data_phase = 1'b1;
            end
            S_DISC: begin
                stop       = 1'b0;
                devsel     = 1'b0;
                data_phase = 1'b1;
            end
            default: begin
                trdy       = 1'b1;
                stop       = 1'b1;
                devsel     = 1'b1;
                data_phase = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pci_target_responder.sv
// Directed bench: expected bus events are queued with their cycle and count when
// stimulus is issued; a negedge monitor pops and compares each observed event.
module tb_pci_target_responder;

    localparam int K_CLAIM    = 0;
    localparam int K_TRDY_ON  = 1;
    localparam int K_TRDY_OFF = 2;
    localparam int K_STOP_ON  = 3;
    localparam int K_STOP_OFF = 4;
    localparam int K_XFER     = 5;
    localparam int K_END      = 6;

    typedef struct {
        int kind;
        int cyc;
        int cnt;
    } ev_t;

    logic       mclk;
    logic       rst;
    logic       frame;
    logic       irdy;
    logic       addr_hit;
    logic       trdy;
    logic       stop;
    logic       devsel;
    logic       data_phase;
    logic [3:0] xfer_count;
    logic       xfer;

    int  cyc;
    int  checks;
    int  failures;
    bit  mon_en;
    int  t0;
    ev_t exp_q[$];

    logic prev_devsel, prev_trdy, prev_stop, prev_dp;

    pci_target_responder #(
        .WAIT_STATES(1),
        .BURST_LIMIT(4),
        .CNT_W      (4)
    ) dut (
        .mclk      (mclk),
        .rst       (rst),
        .frame     (frame),
        .irdy      (irdy),
        .addr_hit  (addr_hit),
        .trdy      (trdy),
        .stop      (stop),
        .devsel    (devsel),
        .data_phase(data_phase),
        .xfer_count(xfer_count),
        .xfer      (xfer)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    initial cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_CLAIM:    return "claim";
            K_TRDY_ON:  return "trdy_on";
            K_TRDY_OFF: return "trdy_off";
            K_STOP_ON:  return "stop_on";
            K_STOP_OFF: return "stop_off";
            K_XFER:     return "xfer";
            default:    return "end";
        endcase
    endfunction

    task automatic expect_ev(input int k, input int c, input int n);
        ev_t e;
        e.kind = k;
        e.cyc  = t0 + c;
        e.cnt  = n;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int k);
        ev_t e;
        bit  bad;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s: got event at cycle %0d count %0d, required no event", kname(k), cyc, xfer_count);
        end else begin
            e   = exp_q.pop_front();
            bad = (e.kind != k) || (e.cyc != cyc);
            if (e.cnt >= 0 && e.cnt != int'(xfer_count)) bad = 1'b1;
            if (k == K_END && (devsel !== 1'b1 || stop !== 1'b1 || trdy !== 1'b1)) bad = 1'b1;
            if (bad) begin
                failures++;
                $display("FAIL event_%s: got %s at cycle %0d count %0d (devsel=%b stop=%b trdy=%b), required %s at cycle %0d count %0d",
                         kname(e.kind), kname(k), cyc, xfer_count, devsel, stop, trdy, kname(e.kind), e.cyc, e.cnt);
            end
        end
    endtask

    // Monitor: detect bus events away from the rising edge.
    always @(negedge mclk) begin
        if (mon_en) begin
            if (prev_devsel === 1'b1 && devsel === 1'b0) observe(K_CLAIM);
            if (prev_trdy === 1'b1 && trdy === 1'b0) observe(K_TRDY_ON);
            if (prev_trdy === 1'b0 && trdy === 1'b1) observe(K_TRDY_OFF);
            if (prev_stop === 1'b1 && stop === 1'b0) observe(K_STOP_ON);
            if (prev_stop === 1'b0 && stop === 1'b1) observe(K_STOP_OFF);
            if (xfer === 1'b1) observe(K_XFER);
            if (prev_dp === 1'b1 && data_phase === 1'b0) observe(K_END);
        end
        prev_devsel = devsel;
        prev_trdy   = trdy;
        prev_stop   = stop;
        prev_dp     = data_phase;
    end

    task automatic check_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Drive frame/irdy for the current cycle, then move to the next one.
    task automatic drive(input logic f, input logic i);
        frame = f;
        irdy  = i;
        @(posedge mclk);
        #1;
    endtask

    task automatic idle_gap();
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b1);
    endtask

    task automatic single_read();
        t0 = cyc;
        addr_hit = 1'b1;
        expect_ev(K_CLAIM, 1, -1);
        expect_ev(K_TRDY_ON, 3, -1);
        expect_ev(K_TRDY_OFF, 4, -1);
        expect_ev(K_XFER, 4, 1);
        expect_ev(K_END, 4, 1);
        drive(1'b0, 1'b1);
        addr_hit = 1'b0;
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        idle_gap();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        mon_en   = 1'b0;
        t0       = 0;
        rst      = 1'b1;
        frame    = 1'b1;
        irdy     = 1'b1;
        addr_hit = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        check_eq("reset_trdy", int'(trdy), 1);
        check_eq("reset_stop", int'(stop), 1);
        check_eq("reset_devsel", int'(devsel), 1);
        check_eq("reset_data_phase", int'(data_phase), 0);
        check_eq("reset_xfer_count", int'(xfer_count), 0);
        check_eq("reset_xfer", int'(xfer), 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        idle_gap();

        // Single read with one wait state.
        single_read();

        // Burst held long enough to hit the four-transfer disconnect.
        t0 = cyc;
        addr_hit = 1'b1;
        expect_ev(K_CLAIM, 1, -1);
        expect_ev(K_TRDY_ON, 3, -1);
        expect_ev(K_XFER, 4, 1);
        expect_ev(K_XFER, 5, 2);
        expect_ev(K_XFER, 6, 3);
        expect_ev(K_TRDY_OFF, 7, -1);
        expect_ev(K_STOP_ON, 7, -1);
        expect_ev(K_XFER, 7, 4);
        expect_ev(K_STOP_OFF, 10, -1);
        expect_ev(K_END, 10, 4);
        drive(1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) drive(1'b0, 1'b0);
        drive(1'b1, 1'b1);
        idle_gap();

        // Address miss: no events at all, IGNORE must clear on bus idle.
        t0 = cyc;
        addr_hit = 1'b0;
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        idle_gap();

        // Initiator holds irdy high for three cycles of trdy low.
        t0 = cyc;
        addr_hit = 1'b1;
        expect_ev(K_CLAIM, 1, -1);
        expect_ev(K_TRDY_ON, 3, -1);
        expect_ev(K_TRDY_OFF, 7, -1);
        expect_ev(K_XFER, 7, 1);
        expect_ev(K_END, 7, 1);
        for (int k = 0; k <= 5; k++) drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        idle_gap();

        // Master abort during the wait state.
        t0 = cyc;
        addr_hit = 1'b1;
        expect_ev(K_CLAIM, 1, -1);
        expect_ev(K_END, 3, 0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        idle_gap();

        // Reset after two transfers of a burst.
        t0 = cyc;
        addr_hit = 1'b1;
        expect_ev(K_CLAIM, 1, -1);
        expect_ev(K_TRDY_ON, 3, -1);
        expect_ev(K_XFER, 4, 1);
        expect_ev(K_XFER, 5, 2);
        expect_ev(K_TRDY_OFF, 6, -1);
        expect_ev(K_END, 6, 0);
        drive(1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) drive(1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b0, 1'b0);
        rst = 1'b0;
        check_eq("midrst_trdy", int'(trdy), 1);
        check_eq("midrst_stop", int'(stop), 1);
        check_eq("midrst_devsel", int'(devsel), 1);
        check_eq("midrst_data_phase", int'(data_phase), 0);
        check_eq("midrst_xfer_count", int'(xfer_count), 0);
        drive(1'b1, 1'b1);
        idle_gap();

        // Normal operation after the mid-burst reset.
        single_read();

        repeat (4) @(posedge mclk);
        #1;
        check_eq("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
